// File: rtl/md_sequencer_if.sv
// md_sequencer_if: E-stage/D-stage handshake and HI/LO read bus of the
// multiply/divide sequencer.
interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, data_a, data_b, d_is_md,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, md_op, data_a, data_b, d_is_md,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer for the E stage of the MIPS pipeline.
// Latches operands on start, models the fixed mult/div latency with a
// counter-driven IDLE/RUN FSM, commits results into HI/LO and generates the
// MD-class hazard stall.
// Optional build macro MD_DIVZERO_FAST_EN: a div/divu whose divisor is zero at
// start is dropped immediately (no busy, no stall, HI/LO unchanged).
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    md_sequencer_if.slave md
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic        uns_q, uns_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic        op_is_div;
    logic        op_is_uns;
    logic        op_is_long;
    logic        divz_skip;
    logic        start_md;
    logic        busy;
    logic        stall;

    // 64-bit product; operands are sign- or zero-extended first so the low
    // 64 bits of the product are correct for both signed and unsigned forms.
    function automatic logic [63:0] mul_result(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        uns);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = uns ? {32'd0, a} : {{32{a[31]}}, a};
        eb = uns ? {32'd0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division truncates toward zero and
    // the remainder takes the dividend's sign; the one overflowing case
    // (most-negative / -1) is pinned to quotient=dividend, remainder=0.
    function automatic logic [63:0] div_result(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        uns);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        quo;
        logic [31:0]        rem;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            quo = 32'd0;
            rem = 32'd0;
        end else if (uns) begin
            quo = a / b;
            rem = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else begin
            quo = sa / sb;
            rem = sa % sb;
        end
        return {rem, quo};
    endfunction

    assign op_is_div  = (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
    assign op_is_uns  = (md.md_op == OP_MULTU) || (md.md_op == OP_DIVU);
    assign op_is_long = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU) || op_is_div;

`ifdef MD_DIVZERO_FAST_EN
    assign divz_skip = op_is_div && (md.data_b == 32'd0);
`else
    assign divz_skip = 1'b0;
`endif

    assign start_md = md.start && op_is_long && !divz_skip;

    // State register: control and architectural HI/LO, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            div_q   <= 1'b0;
            uns_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            uns_q   <= uns_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latches: only meaningful while RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // Next-state: issue from IDLE, count down in RUN, commit on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        uns_d   = uns_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (start_md) begin
                    state_d = RUN;
                    cnt_d   = op_is_div ? DIV_LOAD : MULT_LOAD;
                    div_d   = op_is_div;
                    uns_d   = op_is_uns;
                    a_d     = md.data_a;
                    b_d     = md.data_b;
                end else if (md.start && md.md_op == OP_MTHI) begin
                    hi_d = md.data_a;
                end else if (md.start && md.md_op == OP_MTLO) begin
                    lo_d = md.data_a;
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    if (!div_q) begin
                        {hi_d, lo_d} = mul_result(a_q, b_q, uns_q);
                    end else if (b_q != 32'd0) begin
                        {hi_d, lo_d} = div_result(a_q, b_q, uns_q);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs: busy while RUN; stall holds an MD-class D-stage instruction,
    // including the cycle in which the operation is being issued.
    always_comb begin
        busy = (state_q == RUN);
        stall = md.d_is_md && (busy || start_md);
    end

    assign md.busy  = busy;
    assign md.stall = stall;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

`ifndef SYNTHESIS
    // A new MD instruction reaching E while RUN means the hazard unit failed.
    always @(posedge clk) begin
        if (!reset && state_q == RUN && md.start)
            $warning("md_sequencer: start while busy ignored (op=%0d)", md.md_op);
    end
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed vectors for md_sequencer with hand-computed
// expected results. Honours MD_DIVZERO_FAST_EN for the divide-by-zero case.
module tb_md_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   busy_cnt;
    int   stall_cnt;

`ifdef MD_DIVZERO_FAST_EN
    localparam int DZ_BUSY  = 0;
    localparam int DZ_STALL = 0;
`else
    localparam int DZ_BUSY  = 10;
    localparam int DZ_STALL = 11;
`endif

    md_sequencer_if bus ();

    md_sequencer #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op at posedge+1, then scramble the forwarded operands and
    // count busy and stall cycles until the unit goes idle (bounded).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd);
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.data_a  = a;
        bus.data_b  = b;
        bus.d_is_md = dmd;
        #1;
        stall_cnt = bus.stall ? 1 : 0;
        busy_cnt  = 0;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.md_op  = 3'd0;
        bus.data_a = 32'hDEAD_BEEF;
        bus.data_b = 32'h0;
        #1;
        while (bus.busy && busy_cnt < 40) begin
            busy_cnt++;
            if (bus.stall) stall_cnt++;
            @(posedge clk); #1;
        end
    endtask

    // Single-cycle mthi/mtlo write issued at posedge+1.
    task automatic do_move(input logic [2:0] op, input logic [31:0] a);
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.data_a = a;
        bus.data_b = 32'h0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.md_op   = 3'd0;
        bus.data_a  = 32'h0;
        bus.data_b  = 32'h0;
        bus.d_is_md = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {63'd0, bus.busy},  64'd0);
        check("rst_stall", {63'd0, bus.stall}, 64'd0);
        check("rst_hi",    {32'd0, bus.hi},    64'd0);
        check("rst_lo",    {32'd0, bus.lo},    64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // mult -3 * 7 = -21, with an mflo waiting in D
        do_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1);
        check("mult_busy",  busy_cnt,  5);
        check("mult_stall", stall_cnt, 6);
        check("mult_hi",    {32'd0, bus.hi}, 64'hFFFF_FFFF);
        check("mult_lo",    {32'd0, bus.lo}, 64'hFFFF_FFEB);
        check("mult_stall_after", {63'd0, bus.stall}, 64'd0);

        // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE, no MD instruction in D
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_busy",  busy_cnt,  5);
        check("multu_stall", stall_cnt, 0);
        check("multu_hi",    {32'd0, bus.hi}, 64'h1);
        check("multu_lo",    {32'd0, bus.lo}, 64'hFFFF_FFFE);

        // divu 100 / 7 = 14 r 2
        do_op(3'd4, 32'd100, 32'd7, 1'b1);
        check("divu_busy", busy_cnt, 10);
        check("divu_stall", stall_cnt, 11);
        check("divu_lo", {32'd0, bus.lo}, 64'd14);
        check("divu_hi", {32'd0, bus.hi}, 64'd2);

        // div -7 / 2 = -3 r -1
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
        check("div_neg_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);

        // div 7 / -2 = -3 r 1
        do_op(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        check("div_negb_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
        check("div_negb_hi", {32'd0, bus.hi}, 64'd1);

        // most-negative / -1 overflow case
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo", {32'd0, bus.lo}, 64'h8000_0000);
        check("div_ovf_hi", {32'd0, bus.hi}, 64'd0);

        // mthi while idle: only HI changes, never busy
        do_move(3'd5, 32'h1234_5678);
        check("mthi_hi",   {32'd0, bus.hi},    64'h1234_5678);
        check("mthi_lo",   {32'd0, bus.lo},    64'h8000_0000);
        check("mthi_busy", {63'd0, bus.busy},  64'd0);

        // no-op code is ignored
        do_move(3'd7, 32'h5555_5555);
        check("nop_hi", {32'd0, bus.hi}, 64'h1234_5678);

        // divide by zero leaves HI/LO alone
        do_move(3'd5, 32'hA);
        do_move(3'd6, 32'hB);
        check("mtlo_lo", {32'd0, bus.lo}, 64'hB);
        do_op(3'd3, 32'd50, 32'd0, 1'b1);
        check("dz_busy",  busy_cnt,  DZ_BUSY);
        check("dz_stall", stall_cnt, DZ_STALL);
        check("dz_hi", {32'd0, bus.hi}, 64'hA);
        check("dz_lo", {32'd0, bus.lo}, 64'hB);

        // reset on the third busy cycle of a divide aborts it
        bus.start   = 1'b1;
        bus.md_op   = 3'd4;
        bus.data_a  = 32'd100;
        bus.data_b  = 32'd7;
        bus.d_is_md = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hi",   {32'd0, bus.hi},   64'd0);
        check("abort_lo",   {32'd0, bus.lo},   64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_late_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_late_hi",   {32'd0, bus.hi},   64'd0);
        check("abort_late_lo",   {32'd0, bus.lo},   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
